// File: rtl/gamma_pkg.sv
// Shared types and helpers for the programmable gamma LUT stage.
package gamma_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } gamma_state_e;

  localparam int GAMMA_IN_W  = 8;
  localparam int GAMMA_OUT_W = 12;

  // Expand an in_w-bit index to out_w bits by repeating it from the MSB down,
  // so 0 maps to 0 and full scale maps to all-ones.
  function automatic logic [31:0] gamma_ramp(input logic [31:0] idx,
                                             input int in_w, input int out_w);
    logic [31:0] r;
    int          k;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < out_w) begin
        k = in_w - 1 - ((out_w - 1 - b) % in_w);
        r[b[4:0]] = idx[k[4:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/gamma_lut_ram.sv
// Single-channel 2^IN_W x OUT_W table: one write port, one registered read
// port with read enable. A same-cycle read of the written index sees the old entry.
module gamma_lut_ram #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IN_W-1:0]  waddr_i,
  input  logic [OUT_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic [IN_W-1:0]  raddr_i,
  output logic [OUT_W-1:0] rdata_o
);

  logic [OUT_W-1:0] mem_q [1<<IN_W];
  logic [OUT_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/gamma_lut_rgb.sv
// Runtime-programmable per-channel gamma LUT with linear-ramp fill after reset.
// Define GAMMA_LUT_OUTREG_EN for a registered output stage (latency 2) with skid.
module gamma_lut_rgb
  import gamma_pkg::*;
#(
  parameter int IN_W     = GAMMA_IN_W,
  parameter int OUT_W    = GAMMA_OUT_W,
  parameter int CHANNELS = 3,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*IN_W-1:0]  in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  input  logic                      cfg_we,
  input  logic [CW-1:0]             cfg_chan,
  input  logic [IN_W-1:0]           cfg_addr,
  input  logic [OUT_W-1:0]          cfg_data,
  input  logic                      init_req,
  output logic                      init_busy
);

  localparam int DW = CHANNELS * OUT_W;

  gamma_state_e      state_q, state_d;
  logic [IN_W-1:0]   cnt_q, cnt_d;
  logic              accept;
  logic [OUT_W-1:0]  ramp_w;
  logic [DW-1:0]     ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      if (init_req) begin
        cnt_d = '0;
      end else if (cnt_q == '1) begin
        state_d = RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (init_req) begin
      state_d = INIT;
      cnt_d   = '0;
    end
  end

  assign init_busy = (state_q == INIT);
  assign ramp_w    = OUT_W'(gamma_ramp(32'(cnt_q), IN_W, OUT_W));

  // The fill owns the write port in INIT, so cfg writes there are simply lost.
  genvar c;
  generate
    for (c = 0; c < CHANNELS; c++) begin : g_ch
      logic we_c;
      assign we_c = init_busy || (cfg_we && (cfg_chan == CW'(c)));
      gamma_lut_ram #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we_c),
        .waddr_i (init_busy ? cnt_q : cfg_addr),
        .wdata_i (init_busy ? ramp_w : cfg_data),
        .re_i    (accept),
        .raddr_i (in_data[c*IN_W +: IN_W]),
        .rdata_o (ram_rdata[c*OUT_W +: OUT_W])
      );
    end
  endgenerate

`ifdef GAMMA_LUT_OUTREG_EN
  // RAM stage always drains into an output register plus two skid entries;
  // admitting only while fewer than three beats are in flight keeps it lossless.
  logic          v1_q;
  logic [1:0]    ocnt_q;
  logic [DW-1:0] oq_q [3];
  logic [2:0]    occ;
  logic          pop;
  logic [1:0]    wptr;

  assign occ      = {1'b0, ocnt_q} + {2'b00, v1_q};
  assign in_ready = (state_q == RUN) && (occ < 3'd3);
  assign accept   = in_valid && in_ready;
  assign pop      = (ocnt_q != 2'd0) && out_ready;
  assign wptr     = ocnt_q - {1'b0, pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      ocnt_q <= '0;
      for (int i = 0; i < 3; i++) oq_q[i] <= '0;
    end else begin
      v1_q   <= accept;
      ocnt_q <= ocnt_q - {1'b0, pop} + {1'b0, v1_q};
      if (pop) begin
        oq_q[0] <= oq_q[1];
        oq_q[1] <= oq_q[2];
      end
      if (v1_q) oq_q[wptr] <= ram_rdata;
    end
  end

  assign out_valid = (ocnt_q != 2'd0);
  assign out_data  = oq_q[0];
`else
  logic out_valid_q;

  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         out_valid_q <= 1'b0;
    else if (accept)    out_valid_q <= 1'b1;
    else if (out_ready) out_valid_q <= 1'b0;
  end

  assign out_valid = out_valid_q;
  assign out_data  = ram_rdata;
`endif

endmodule
